mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch stage (stage 1) and the data-memory stage (stage 4) of the 5-stage pipeline.
- Latches one request at a time, drives the memory until it acknowledges, then returns read data or write completion to the owner.
- Emits a per-port stall for the hazard logic.
- Data port has priority, bounded by a starvation counter; a fetch flush on a taken jump discards stale fetch data.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_starve.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds the FSM state encoding, grant kinds and access-width codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    localparam logic [1:0] WL_BYTE = 2'd0;
    localparam logic [1:0] WL_HALF = 2'd1;
    localparam logic [1:0] WL_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Starvation counter and priority select for the memory port arbiter.
// Ports: clk/rst, arb_en_i (arbiter idle), i_elig_i, d_elig_i -> gnt_o.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en_i,
    input  logic   i_elig_i,
    input  logic   d_elig_i,
    output grant_e gnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_max;

    assign at_max = (cnt_q == CW'(STARVE_MAX));

    // Data wins unless a waiting fetch has already lost STARVE_MAX times.
    // The count never passes STARVE_MAX: at the limit a waiting fetch wins.
    always_comb begin
        gnt_o = GNT_NONE;
        cnt_d = cnt_q;
        if (arb_en_i) begin
            if (d_elig_i && !(i_elig_i && at_max)) begin
                gnt_o = GNT_D;
                cnt_d = i_elig_i ? cnt_q + CW'(1) : '0;
            end else if (i_elig_i) begin
                gnt_o = GNT_I;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data stages.
// Ports: clk/rst; i_* fetch port; d_* data port; m_* memory side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    input  logic            i_flush,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [1:0]      d_wl,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_stall,
    output logic            m_req,
    output logic            m_we,
    output logic [1:0]      m_wl,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata
);

    state_e          state_q,   state_d;
    logic            drop_q,    drop_d;
    logic            m_req_q,   m_req_d;
    logic            m_we_q,    m_we_d;
    logic [1:0]      m_wl_q,    m_wl_d;
    logic [XLEN-1:0] m_addr_q,  m_addr_d;
    logic [XLEN-1:0] m_wdata_q, m_wdata_d;
    logic            i_rv_q,    i_rv_d;
    logic [XLEN-1:0] i_rdata_q, i_rdata_d;
    logic            d_done_q,  d_done_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;

    grant_e gnt;
    logic   i_elig;
    logic   arb_en;

    assign i_elig = i_req & ~i_flush;
    assign arb_en = (state_q == ST_IDLE);

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .arb_en_i (arb_en),
        .i_elig_i (i_elig),
        .d_elig_i (d_req),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_wl_d    = m_wl_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rv_d    = 1'b0;
        i_rdata_d = i_rdata_q;
        d_done_d  = 1'b0;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (gnt == GNT_D) begin
                    state_d   = ST_BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_wl_d    = d_wl;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (gnt == GNT_I) begin
                    state_d  = ST_BUSY_I;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_wl_d   = WL_WORD;
                    m_addr_d = i_addr;
                end
            end
            ST_BUSY_I: begin
                if (i_flush) begin
                    drop_d = 1'b1;
                end
                // A flush on the ack cycle itself also kills the response.
                if (m_ack) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                    drop_d  = 1'b0;
                    if (!(drop_q || i_flush)) begin
                        i_rv_d    = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end
            end
            ST_BUSY_D: begin
                if (m_ack) begin
                    state_d   = ST_IDLE;
                    m_req_d   = 1'b0;
                    d_done_d  = 1'b1;
                    d_rdata_d = m_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            drop_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_wl_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rv_q    <= 1'b0;
            i_rdata_q <= '0;
            d_done_q  <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_wl_q    <= m_wl_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rv_q    <= i_rv_d;
            i_rdata_q <= i_rdata_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_wl     = m_wl_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign i_rvalid = i_rv_q;
    assign i_rdata  = i_rdata_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;

    assign i_stall = i_req & ~i_rv_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed scenarios plus a random run against a behavioural model.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int SMAX = 4;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req, i_flush, i_rvalid, i_stall;
    logic [XLEN-1:0] i_addr, i_rdata;
    logic            d_req, d_we, d_done, d_stall;
    logic [1:0]      d_wl;
    logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
    logic            m_req, m_we, m_ack;
    logic [1:0]      m_wl;
    logic [XLEN-1:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (SMAX),
        .CW         (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_stall  (i_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_wl     (d_wl),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_wl     (m_wl),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // memory responder
    int          mem_lat = 1;
    int          wcnt    = 0;
    logic        fix_en  = 1'b0;
    logic [31:0] fix_val = '0;

    // response order as seen on the DUT outputs
    byte order_q[$];

    // behavioural model: owner 0 none, 1 fetch, 2 data
    int          ms;
    int          mcnt;
    bit          mdrop;
    logic        e_m_req, e_m_we, e_i_rv, e_d_done;
    logic [1:0]  e_m_wl;
    logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;

    task automatic model_tick();
        bit ie;
        e_i_rv   = 1'b0;
        e_d_done = 1'b0;
        if (rst) begin
            ms = 0; mdrop = 0; mcnt = 0;
            e_m_req = 0; e_m_we = 0; e_m_wl = 0;
            e_m_addr = 0; e_m_wdata = 0;
            e_i_rdata = 0; e_d_rdata = 0;
            return;
        end
        ie = i_req && !i_flush;
        if (ms == 0) begin
            if (d_req && !(ie && mcnt == SMAX)) begin
                mcnt = ie ? mcnt + 1 : 0;
                ms = 2;
                e_m_req = 1; e_m_we = d_we; e_m_wl = d_wl;
                e_m_addr = d_addr; e_m_wdata = d_wdata;
            end else if (ie) begin
                mcnt = 0;
                ms = 1;
                e_m_req = 1; e_m_we = 0; e_m_wl = 2'd2;
                e_m_addr = i_addr;
            end
        end else if (m_ack) begin
            if (ms == 1 && !(mdrop || i_flush)) begin
                e_i_rv = 1; e_i_rdata = m_rdata;
            end
            if (ms == 2) begin
                e_d_done = 1; e_d_rdata = m_rdata;
            end
            ms = 0; mdrop = 0; e_m_req = 0;
        end else if (ms == 1 && i_flush) begin
            mdrop = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
        if (i_rvalid) order_q.push_back(8'h49);
        if (d_done)   order_q.push_back(8'h44);
        if (m_req && !m_ack) begin
            wcnt++;
            if (wcnt >= mem_lat) begin
                m_ack   = 1'b1;
                m_rdata = fix_en ? fix_val : (m_addr ^ K);
                wcnt    = 0;
            end else begin
                m_rdata = $urandom;
            end
        end else begin
            m_ack   = 1'b0;
            m_rdata = $urandom;
            wcnt    = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1; i_req = 0; i_flush = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_wl = 0; d_addr = 0; d_wdata = 0;
        m_ack = 0; m_rdata = 0; wcnt = 0; fix_en = 0; mem_lat = 1;
        tick();
        rst = 0;
        order_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({m_req, m_we, m_wl, m_addr, m_wdata, i_rvalid, i_rdata,
             d_done, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got req=%b we=%b wl=%0d a=%h rv=%b done=%b want all 0",
                     m_req, m_we, m_wl, m_addr, i_rvalid, d_done);
        end
        n_cmp++;
        if ({i_stall, d_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_stall: got %b%b want 00", i_stall, d_stall);
        end
    endtask

    task automatic test_fetch();
        bit seen = 0;
        bit got  = 0;
        do_reset();
        mem_lat = 2; fix_en = 1; fix_val = 32'h0050_0093;
        i_req = 1; i_addr = 32'h40;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            if (m_req && !got) begin
                got = 1;
                n_cmp++;
                if (m_addr !== 32'h40 || m_we !== 1'b0 || m_wl !== 2'd2) begin
                    n_fail++;
                    $display("FAIL fetch_m: got a=%h we=%b wl=%0d want 40/0/2",
                             m_addr, m_we, m_wl);
                end
            end
            n_cmp++;
            if (i_stall !== !e_i_rv) begin
                n_fail++;
                $display("FAIL fetch_stall c%0d: got %b want %b", c, i_stall, !e_i_rv);
            end
            if (i_rvalid) begin
                seen = 1;
                n_cmp++;
                if (i_rdata !== 32'h0050_0093 || c != 2) begin
                    n_fail++;
                    $display("FAIL fetch_data: got %h at c%0d want 00500093 at c2", i_rdata, c);
                end
            end
        end
        if (!seen) begin
            n_fail++; n_cmp++;
            $display("FAIL fetch_timeout: got no i_rvalid want pulse");
        end
        i_req = 0;
        tick();
        n_cmp++;
        if (i_rvalid !== 1'b0 || m_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse: got rv=%b req=%b want 0 0", i_rvalid, m_req);
        end
        fix_en = 0;
    endtask

    task automatic test_store();
        int  dn = 0;
        int  rv = 0;
        bit  got = 0;
        do_reset();
        mem_lat = 2;
        d_req = 1; d_we = 1; d_wl = 2'd0; d_addr = 32'h1004; d_wdata = 32'hAB;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_req && !got) begin
                got = 1;
                n_cmp++;
                if ({m_we, m_wl, m_addr, m_wdata} !== {1'b1, 2'd0, 32'h1004, 32'hAB}) begin
                    n_fail++;
                    $display("FAIL store_m: got we=%b wl=%0d a=%h wd=%h want 1/0/1004/ab",
                             m_we, m_wl, m_addr, m_wdata);
                end
            end
            if (d_done) begin dn++; d_req = 0; end
            if (i_rvalid) rv++;
        end
        n_cmp++;
        if (dn != 1 || rv != 0) begin
            n_fail++;
            $display("FAIL store_resp: got done=%0d rv=%0d want 1 0", dn, rv);
        end
    endtask

    task automatic test_contention();
        string pat = "DDDDIDDDDI";
        do_reset();
        mem_lat = 1;
        d_req = 1; d_we = 0; d_wl = 2'd2; d_addr = 32'h2000;
        i_req = 1; i_addr = 32'h100;
        for (int c = 0; c < 60 && order_q.size() < 10; c++) begin
            tick();
            if (m_req) begin
                n_cmp++;
                if (m_addr !== e_m_addr) begin
                    n_fail++;
                    $display("FAIL cont_addr c%0d: got %h want %h", c, m_addr, e_m_addr);
                end
            end
        end
        n_cmp++;
        if (order_q.size() < 10) begin
            n_fail++;
            $display("FAIL cont_timeout: got %0d responses want 10", order_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                n_cmp++;
                if (order_q[k] !== pat[k]) begin
                    n_fail++;
                    $display("FAIL cont_order[%0d]: got %c want %c", k, order_q[k], pat[k]);
                end
            end
        end
        d_req = 0; i_req = 0;
        tick(); tick();
    endtask

    task automatic fetch_until_rv(input string nm, input logic [31:0] want);
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (i_rvalid) begin
                seen = 1;
                n_cmp++;
                if (i_rdata !== want) begin
                    n_fail++;
                    $display("FAIL %s_data: got %h want %h", nm, i_rdata, want);
                end
            end
        end
        if (!seen) begin
            n_fail++; n_cmp++;
            $display("FAIL %s_timeout: got no i_rvalid want pulse", nm);
        end
        i_req = 0;
        tick();
    endtask

    task automatic test_flush();
        bit hit = 0;
        // flush while the fetch is outstanding
        do_reset();
        mem_lat = 3;
        i_req = 1; i_addr = 32'h60;
        for (int c = 0; c < 5 && !m_req; c++) tick();
        i_flush = 1; i_addr = 32'h80;
        tick();
        i_flush = 0;
        fetch_until_rv("flush_busy", 32'h80 ^ K);
        // flush on the very cycle the memory acks
        do_reset();
        mem_lat = 2;
        i_req = 1; i_addr = 32'h60;
        for (int c = 0; c < 8 && !hit; c++) begin
            tick();
            hit = m_ack;
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL flush_ack_wait: got no m_ack want ack");
        end
        i_flush = 1; i_addr = 32'h80;
        tick();
        n_cmp++;
        if (i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ack_rv: got %b want 0", i_rvalid);
        end
        i_flush = 0;
        fetch_until_rv("flush_ack", 32'h80 ^ K);
    endtask

    task automatic test_flush_idle();
        do_reset();
        i_req = 1; i_flush = 1; i_addr = 32'h90;
        tick();
        n_cmp++;
        if (m_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_nogrant: got m_req=%b want 0", m_req);
        end
        i_flush = 0;
        mem_lat = 5;
        tick();
        n_cmp++;
        if (m_req !== 1'b1 || m_addr !== 32'h90) begin
            n_fail++;
            $display("FAIL flush_idle_grant: got req=%b a=%h want 1 90", m_req, m_addr);
        end
        i_req = 0;
    endtask

    task automatic test_reset_busy();
        int dn = 0;
        do_reset();
        mem_lat = 100;
        d_req = 1; d_we = 0; d_addr = 32'h3000;
        for (int c = 0; c < 5 && !m_req; c++) tick();
        rst = 1; m_ack = 1; m_rdata = 32'h1234;
        tick();
        n_cmp++;
        if (m_req !== 1'b0 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got req=%b done=%b want 0 0", m_req, d_done);
        end
        rst = 0; d_req = 0; m_ack = 1; m_rdata = 32'h5678;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (d_done || i_rvalid || m_req) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL rst_stray_ack: got %0d active cycles want 0", dn);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!m_req) mem_lat = $urandom_range(1, 3);
            if (!i_req || i_rvalid || i_flush) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = $urandom & 32'h0000_FFFC;
            end
            i_flush = ($urandom_range(0, 7) == 0);
            if (!d_req || d_done) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = 1'($urandom_range(0, 1));
                d_wl    = 2'($urandom_range(0, 2));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            tick();
            n_cmp++;
            if (m_req !== e_m_req) begin
                n_fail++;
                $display("FAIL rnd_req c%0d: got %b want %b", c, m_req, e_m_req);
            end
            if (e_m_req) begin
                n_cmp++;
                if ({m_we, m_wl, m_addr} !== {e_m_we, e_m_wl, e_m_addr}) begin
                    n_fail++;
                    $display("FAIL rnd_mfields c%0d: got %b/%0d/%h want %b/%0d/%h",
                             c, m_we, m_wl, m_addr, e_m_we, e_m_wl, e_m_addr);
                end
            end
            if (e_m_req && e_m_we) begin
                n_cmp++;
                if (m_wdata !== e_m_wdata) begin
                    n_fail++;
                    $display("FAIL rnd_wdata c%0d: got %h want %h", c, m_wdata, e_m_wdata);
                end
            end
            n_cmp++;
            if ({i_rvalid, d_done} !== {e_i_rv, e_d_done}) begin
                n_fail++;
                $display("FAIL rnd_resp c%0d: got rv=%b done=%b want %b %b",
                         c, i_rvalid, d_done, e_i_rv, e_d_done);
            end
            n_cmp++;
            if (i_rdata !== e_i_rdata) begin
                n_fail++;
                $display("FAIL rnd_irdata c%0d: got %h want %h", c, i_rdata, e_i_rdata);
            end
            if (e_d_done && !e_m_we) begin
                n_cmp++;
                if (d_rdata !== e_d_rdata) begin
                    n_fail++;
                    $display("FAIL rnd_drdata c%0d: got %h want %h", c, d_rdata, e_d_rdata);
                end
            end
            n_cmp++;
            if ({i_stall, d_stall} !== {i_req & !e_i_rv, d_req & !e_d_done}) begin
                n_fail++;
                $display("FAIL rnd_stall c%0d: got %b%b want %b%b", c, i_stall, d_stall,
                         i_req & !e_i_rv, d_req & !e_d_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_flush();
        test_flush_idle();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
